// File: rtl/i2s_adc_rx_if.sv
// Stereo frame port between the I2S ADC receiver and the recorder datapath.
`timescale 1ns/1ps
interface i2s_adc_rx_if #(
  parameter int DATA_W = 16
);
  logic [DATA_W-1:0] o_left;
  logic [DATA_W-1:0] o_right;
  logic              o_valid;
  logic              i_ready;
  logic              o_overrun;
  logic              i_clr_ovr;

  modport master (
    output o_left, o_right, o_valid, o_overrun,
    input  i_ready, i_clr_ovr
  );

  modport slave (
    input  o_left, o_right, o_valid, o_overrun,
    output i_ready, i_clr_ovr
  );
endinterface

// File: rtl/i2s_adc_rx.sv
// WM8731 ADC receiver: synchronises BCLK/ADCLRCK/ADCDAT into clk, deserialises
// I2S left/right words and presents stereo frames on a valid/ready port.
//
// state  | meaning
// IDLE   | waiting for init_done and a falling LRCK (start of a left word)
// DELAY  | skipping the one-BCLK I2S offset after an LRCK edge
// SHIFT  | shifting in DATA_W bits, MSB first
// PAD    | ignoring surplus bits until the next LRCK edge
`timescale 1ns/1ps
module i2s_adc_rx #(
  parameter int DATA_W      = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          init_done,
  input  logic          AUD_BCLK,
  input  logic          AUD_ADCLRCK,
  input  logic          AUD_ADCDAT,
  i2s_adc_rx_if.master  rx
);

  localparam int CNT_W = $clog2(DATA_W) + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DELAY = 2'd1,
    ST_SHIFT = 2'd2,
    ST_PAD   = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] bclk_sync_q;
  logic [SYNC_STAGES-1:0] lrck_sync_q;
  logic [SYNC_STAGES-1:0] dat_sync_q;
  logic                   bclk_prev_q;
  logic                   lrck_last_q;
  logic                   bclk_s;
  logic                   lrck_s;
  logic                   dat_s;
  logic                   bclk_rise;
  logic                   lrck_fall;
  logic                   lrck_edge;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic [DATA_W-1:0]      shift_q, shift_d;
  logic                   word_done;

  logic [DATA_W-1:0]      left_hold_q, left_hold_d;
  logic [DATA_W-1:0]      right_hold_q, right_hold_d;
  logic                   left_held_q, left_held_d;
  logic                   frame_pend_q, frame_pend_d;

  logic [DATA_W-1:0]      left_q, left_d;
  logic [DATA_W-1:0]      right_q, right_d;
  logic                   valid_q, valid_d;
  logic                   ovr_q, ovr_d;
  logic                   load_frame;

  assign bclk_s = bclk_sync_q[SYNC_STAGES-1];
  assign lrck_s = lrck_sync_q[SYNC_STAGES-1];
  assign dat_s  = dat_sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      bclk_sync_q <= '0;
      lrck_sync_q <= '0;
      dat_sync_q  <= '0;
      bclk_prev_q <= 1'b0;
      lrck_last_q <= 1'b0;
    end else begin
      bclk_sync_q <= {bclk_sync_q[SYNC_STAGES-2:0], AUD_BCLK};
      lrck_sync_q <= {lrck_sync_q[SYNC_STAGES-2:0], AUD_ADCLRCK};
      dat_sync_q  <= {dat_sync_q[SYNC_STAGES-2:0], AUD_ADCDAT};
      bclk_prev_q <= bclk_s;
      if (bclk_rise) begin
        lrck_last_q <= lrck_s;
      end
    end
  end

  // LRCK is only compared at bit-clock rises, so glitches between bits are invisible.
  assign bclk_rise = bclk_s & ~bclk_prev_q;
  assign lrck_fall = bclk_rise & lrck_last_q & ~lrck_s;
  assign lrck_edge = bclk_rise & (lrck_last_q ^ lrck_s);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      shift_q <= shift_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!init_done) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  if (lrck_fall) state_d = ST_DELAY;
        ST_DELAY: if (bclk_rise) state_d = ST_SHIFT;
        ST_SHIFT: begin
          if (lrck_edge) begin
            state_d = ST_DELAY;
          end else if (bclk_rise && count_q == CNT_W'(DATA_W - 1)) begin
            state_d = ST_PAD;
          end
        end
        ST_PAD:   if (lrck_edge) state_d = ST_DELAY;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    count_d   = '0;
    shift_d   = shift_q;
    word_done = 1'b0;
    if (state_q == ST_SHIFT) begin
      count_d = count_q;
      if (init_done && bclk_rise && !lrck_edge) begin
        shift_d = {shift_q[DATA_W-2:0], dat_s};
        count_d = count_q + CNT_W'(1);
        if (count_q == CNT_W'(DATA_W - 1)) begin
          word_done = 1'b1;
        end
      end
    end
  end

  // A frame is only formed from a right word that directly follows a held left word.
  always_comb begin
    left_hold_d  = left_hold_q;
    right_hold_d = right_hold_q;
    left_held_d  = left_held_q;
    frame_pend_d = 1'b0;
    if (state_q == ST_IDLE) begin
      left_held_d = 1'b0;
    end
    if (word_done) begin
      if (!lrck_s) begin
        left_hold_d = shift_d;
        left_held_d = 1'b1;
      end else begin
        if (left_held_q) begin
          right_hold_d = shift_d;
          frame_pend_d = 1'b1;
        end
        left_held_d = 1'b0;
      end
    end
  end

  always_comb begin
    load_frame = frame_pend_q && (!valid_q || rx.i_ready);
    valid_d    = valid_q;
    left_d     = left_q;
    right_d    = right_q;
    ovr_d      = ovr_q;
    if (load_frame) begin
      valid_d = 1'b1;
      left_d  = left_hold_q;
      right_d = right_hold_q;
    end else if (valid_q && rx.i_ready) begin
      valid_d = 1'b0;
    end
    if (frame_pend_q && !load_frame) begin
      ovr_d = 1'b1;
    end else if (rx.i_clr_ovr) begin
      ovr_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      left_hold_q  <= '0;
      right_hold_q <= '0;
      left_held_q  <= 1'b0;
      frame_pend_q <= 1'b0;
      left_q       <= '0;
      right_q      <= '0;
      valid_q      <= 1'b0;
      ovr_q        <= 1'b0;
    end else begin
      left_hold_q  <= left_hold_d;
      right_hold_q <= right_hold_d;
      left_held_q  <= left_held_d;
      frame_pend_q <= frame_pend_d;
      left_q       <= left_d;
      right_q      <= right_d;
      valid_q      <= valid_d;
      ovr_q        <= ovr_d;
    end
  end

  assign rx.o_left    = left_q;
  assign rx.o_right   = right_q;
  assign rx.o_valid   = valid_q;
  assign rx.o_overrun = ovr_q;

endmodule

// File: tb/tb_i2s_adc_rx.sv
// Bench for i2s_adc_rx: a codec model drives I2S half-frames and a frame-level
// model predicts which stereo frames must come out of the port.
`timescale 1ns/1ps
module tb_i2s_adc_rx;

  localparam int DATA_W = 16;

  logic clk = 1'b0;
  logic reset;
  logic init_done;
  logic bclk;
  logic lrck;
  logic dat;

  i2s_adc_rx_if #(.DATA_W(DATA_W)) rx_if ();

  i2s_adc_rx #(.DATA_W(DATA_W), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .init_done  (init_done),
    .AUD_BCLK   (bclk),
    .AUD_ADCLRCK(lrck),
    .AUD_ADCDAT (dat),
    .rx         (rx_if)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int valid_cycles = 0;
  int stable_viol = 0;
  bit prev_stall = 1'b0;
  logic [31:0] prev_data = '0;

  logic [31:0] got_q[$];
  logic [31:0] exp_q[$];

  // frame-level model state
  bit          m_synced = 1'b0;
  bit          m_have_left = 1'b0;
  bit          m_stall = 1'b0;
  bit          m_hold_v = 1'b0;
  bit          m_ovr = 1'b0;
  bit          m_prev_lr = 1'b1;
  logic [15:0] m_left = '0;
  logic [31:0] m_hold = '0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      if (prev_stall && !reset && {rx_if.o_left, rx_if.o_right} !== prev_data) stable_viol++;
      prev_stall = rx_if.o_valid && !rx_if.i_ready;
      prev_data  = {rx_if.o_left, rx_if.o_right};
      if (rx_if.o_valid) begin
        valid_cycles++;
        if (rx_if.i_ready) got_q.push_back({rx_if.o_left, rx_if.o_right});
      end
    end
  end

  task automatic deliver(input logic [31:0] frame);
    if (m_stall) begin
      if (m_hold_v) m_ovr = 1'b1;
      else begin
        m_hold_v = 1'b1;
        m_hold   = frame;
      end
    end else begin
      exp_q.push_back(frame);
    end
  endtask

  task automatic drive_bit(input bit lr, input bit b);
    bclk = 1'b0;
    lrck = lr;
    dat  = b;
    repeat (4) @(negedge clk);
    bclk = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  // One LRCK half-period: slot 0 carries the LRCK change, slot 1 is the I2S
  // offset, then the codec word MSB first, then pad bits up to 32 slots.
  task automatic send_half(input bit lr, input logic [15:0] w, input int clen,
                           input int cut, input int drop_at, input int rst_at);
    logic [23:0] cw;
    int nslots;
    bit full;
    cw = (clen == 24) ? {w, 8'($urandom)} : {8'h00, w};
    nslots = (cut >= 0) ? 2 + cut : 32;
    if (!lr && m_prev_lr && init_done) m_synced = 1'b1;
    for (int s = 0; s < nslots; s++) begin
      bit b;
      if (s == drop_at) begin
        init_done   = 1'b0;
        m_synced    = 1'b0;
        m_have_left = 1'b0;
      end
      if (s == rst_at) begin
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        m_synced = 1'b0; m_have_left = 1'b0; m_hold_v = 1'b0; m_ovr = 1'b0;
        check_val("rst_valid", 32'(rx_if.o_valid), 32'd0);
        check_val("rst_left", 32'(rx_if.o_left), 32'd0);
        check_val("rst_right", 32'(rx_if.o_right), 32'd0);
        check_val("rst_ovr", 32'(rx_if.o_overrun), 32'd0);
      end
      b = (s >= 2 && s < 2 + clen) ? cw[clen-1-(s-2)] : 1'($urandom);
      drive_bit(lr, b);
    end
    full = (cut < 0) && (drop_at < 0) && (rst_at < 0);
    if (m_synced && full) begin
      if (!lr) begin
        m_have_left = 1'b1;
        m_left      = w;
      end else begin
        if (m_have_left) deliver({m_left, w});
        m_have_left = 1'b0;
      end
    end else begin
      m_have_left = 1'b0;
    end
    m_prev_lr = lr;
  endtask

  task automatic send_frame(input logic [15:0] l, input logic [15:0] r, input int clen);
    send_half(1'b0, l, clen, -1, -1, -1);
    send_half(1'b1, r, clen, -1, -1, -1);
  endtask

  task automatic compare_frames(input string tag);
    int n;
    repeat (24) @(negedge clk);
    check_val({tag, "_nframes"}, 32'(got_q.size()), 32'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check_val({tag, "_frame"}, got_q[i], exp_q[i]);
    check_val({tag, "_ovr"}, 32'(rx_if.o_overrun), 32'(m_ovr));
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int v0;
    reset = 1'b1;
    init_done = 1'b0;
    bclk = 1'b0;
    lrck = 1'b1;
    dat = 1'b0;
    rx_if.i_ready = 1'b1;
    rx_if.i_clr_ovr = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_val("init_valid", 32'(rx_if.o_valid), 32'd0);
    check_val("init_left", 32'(rx_if.o_left), 32'd0);
    check_val("init_right", 32'(rx_if.o_right), 32'd0);
    check_val("init_ovr", 32'(rx_if.o_overrun), 32'd0);

    // receiver stays idle without init_done
    send_frame(16'h1234, 16'h5678, 16);
    send_half(1'b0, 16'h1111, 16, -1, -1, -1);
    send_half(1'b1, 16'h2222, 16, -1, -1, -1);
    compare_frames("no_init");
    init_done = 1'b1;

    v0 = valid_cycles;
    repeat (4) send_frame(16'hA5C3, 16'h0F01, 16);
    check_val("t2_pulses", 32'(valid_cycles - v0), 32'd4);
    compare_frames("t2");

    repeat (6) send_frame(16'($urandom), 16'($urandom), ($urandom_range(0, 1) == 1) ? 24 : 16);
    compare_frames("rnd");

    repeat (3) send_frame(16'h8000, 16'h7FFF, 24);
    compare_frames("t3");

    // consumer stalls for three frames
    rx_if.i_ready = 1'b0;
    m_stall = 1'b1;
    repeat (3) send_frame(16'($urandom), 16'($urandom), 16);
    repeat (8) @(negedge clk);
    check_val("t4_valid", 32'(rx_if.o_valid), 32'd1);
    check_val("t4_held", {rx_if.o_left, rx_if.o_right}, m_hold);
    check_val("t4_ovr_set", 32'(rx_if.o_overrun), 32'(m_ovr));
    check_val("t4_stable", 32'(stable_viol), 32'd0);
    rx_if.i_clr_ovr = 1'b1;
    @(negedge clk);
    rx_if.i_clr_ovr = 1'b0;
    m_ovr = 1'b0;
    @(negedge clk);
    check_val("t4_ovr_clr", 32'(rx_if.o_overrun), 32'd0);
    rx_if.i_ready = 1'b1;
    m_stall = 1'b0;
    if (m_hold_v) exp_q.push_back(m_hold);
    m_hold_v = 1'b0;
    repeat (4) @(negedge clk);
    check_val("t4_released", 32'(rx_if.o_valid), 32'd0);
    compare_frames("t4");

    // init_done drops in the middle of the right word
    send_half(1'b0, 16'($urandom), 16, -1, -1, -1);
    send_half(1'b1, 16'($urandom), 16, -1, 8, -1);
    init_done = 1'b1;
    repeat (2) send_frame(16'($urandom), 16'($urandom), 16);
    compare_frames("t5");

    // short words: LRCK toggles after 10 bits
    send_half(1'b0, 16'($urandom), 16, 10, -1, -1);
    send_half(1'b1, 16'($urandom), 16, -1, -1, -1);
    send_frame(16'($urandom), 16'($urandom), 16);
    send_half(1'b0, 16'($urandom), 16, -1, -1, -1);
    send_half(1'b1, 16'($urandom), 16, 10, -1, -1);
    repeat (2) send_frame(16'($urandom), 16'($urandom), 16);
    compare_frames("t6");

    // reset mid-frame while a stalled frame and an overrun are pending
    rx_if.i_ready = 1'b0;
    m_stall = 1'b1;
    repeat (2) send_frame(16'($urandom), 16'($urandom), 16);
    check_val("t1_pre_ovr", 32'(rx_if.o_overrun), 32'(m_ovr));
    send_half(1'b0, 16'($urandom), 16, -1, -1, 6);
    rx_if.i_ready = 1'b1;
    m_stall = 1'b0;
    v0 = valid_cycles;
    send_half(1'b1, 16'($urandom), 16, -1, -1, -1);
    check_val("t1_no_valid", 32'(valid_cycles - v0), 32'd0);
    repeat (2) send_frame(16'($urandom), 16'($urandom), 16);
    compare_frames("t1");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
